// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: bus size/RW codes,
// FSM state encoding, request payload and small byte-lane helpers.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_SPLIT  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
   } req_t;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
      case (size)
         SZ_BYTE: return 1'b1;
         SZ_HALF: return lsb[0] == 1'b0;
         SZ_WORD: return lsb == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Lane of the first (lowest-address) byte of a split access.
   function automatic logic [1:0] last_lane(input logic [1:0] size);
      return (size == SZ_WORD) ? 2'd3 : 2'd1;
   endfunction

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] lane);
      return w[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of right-justified load data to 32 bits.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] ext_c
);

   always_comb begin
      case (size)
         SZ_BYTE: ext_c = {{24{sgn & raw[7]}}, raw[7:0]};
         SZ_HALF: ext_c = {{16{sgn & raw[15]}}, raw[15:0]};
         default: ext_c = raw;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the data-memory port: one request at a time,
// aligned accesses in one bus cycle, misaligned ones split into bytes.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W           = 8,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_a,
   output logic [31:0]       mem_di,
   input  logic [31:0]       mem_do,
   output logic [1:0]        mem_size,
   output logic              mem_rw,
   output logic              mem_e
);

   state_t            state_q, state_d;
   req_t              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        k_q;
   logic [31:0]       asm_q, asm_next;
   logic              accept_c;
   logic [1:0]        k_nxt;
   logic [31:0]       raw_c, ext_c;

   logic              req_ready_d, resp_valid_d, resp_err_d, mem_rw_d, mem_e_d;
   logic [31:0]       resp_rdata_d, mem_di_d;
   logic [ADDR_W-1:0] mem_a_d;
   logic [1:0]        mem_size_d;

   assign accept_c = (state_q == ST_IDLE) && req_valid && req_ready;
   assign k_nxt    = k_q + 2'd1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (req_size == SZ_ILL)                       state_d = ST_RESP;
               else if (is_aligned(req_size, req_addr[1:0])) state_d = ST_ACCESS;
               else if (ALLOW_MISALIGNED)                    state_d = ST_SPLIT;
               else                                          state_d = ST_RESP;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_SPLIT:  if (k_q == last_lane(req_q.size)) state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Byte assembly: the first byte fetched lands in the most significant lane
   always_comb begin
      asm_next = asm_q;
      if (state_q == ST_SPLIT)
         asm_next[{last_lane(req_q.size) - k_q, 3'b000} +: 8] = mem_do[7:0];
   end

   assign raw_c = (state_q == ST_ACCESS) ? mem_do : asm_next;

   load_extend u_load_extend (
      .raw   (raw_c),
      .size  (req_q.size),
      .sgn   (req_q.sgn),
      .ext_c (ext_c)
   );

   // Output logic: values the output registers take at the next edge
   always_comb begin
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_a_d      = '0;
      mem_di_d     = '0;
      mem_size_d   = SZ_BYTE;
      mem_rw_d     = MEM_READ;
      mem_e_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               case (state_d)
                  ST_ACCESS: begin
                     mem_a_d    = req_addr;
                     mem_di_d   = req_wdata;
                     mem_size_d = req_size;
                     mem_rw_d   = req_rw;
                     mem_e_d    = req_rw;
                  end
                  ST_SPLIT: begin
                     mem_a_d  = req_addr;
                     mem_di_d = {24'h0, pick_byte(req_wdata, last_lane(req_size))};
                     mem_rw_d = req_rw;
                     mem_e_d  = req_rw;
                  end
                  default: begin
                     resp_valid_d = 1'b1;
                     resp_err_d   = 1'b1;
                  end
               endcase
            end
         end
         ST_ACCESS: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = (req_q.rw == MEM_WRITE) ? 32'h0 : ext_c;
         end
         ST_SPLIT: begin
            if (k_q == last_lane(req_q.size)) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = (req_q.rw == MEM_WRITE) ? 32'h0 : ext_c;
            end else begin
               mem_a_d  = addr_q + ADDR_W'(k_nxt);
               mem_di_d = {24'h0, pick_byte(req_q.wdata, last_lane(req_q.size) - k_nxt)};
               mem_rw_d = req_q.rw;
               mem_e_d  = req_q.rw;
            end
         end
         default: ;
      endcase
   end

   // Request latch and split bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q  <= '0;
         addr_q <= '0;
         k_q    <= '0;
         asm_q  <= '0;
      end else if (accept_c) begin
         req_q  <= '{rw: req_rw, size: req_size, sgn: req_signed, wdata: req_wdata};
         addr_q <= req_addr;
         k_q    <= '0;
         asm_q  <= '0;
      end else begin
         asm_q <= asm_next;
         if (state_q == ST_SPLIT) k_q <= k_nxt;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_a      <= '0;
         mem_di     <= '0;
         mem_size   <= SZ_BYTE;
         mem_rw     <= MEM_READ;
         mem_e      <= 1'b0;
      end else begin
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
         mem_a      <= mem_a_d;
         mem_di     <= mem_di_d;
         mem_size   <= mem_size_d;
         mem_rw     <= mem_rw_d;
         mem_e      <= mem_e_d;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory, a request-level reference
// model that expands each accepted request into its expected per-cycle trace.
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int unsigned AW = 8;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] di;
      logic [1:0]  sz;
      logic        rw;
      logic        e;
      logic        rv;
      logic        err;
      logic [31:0] rd;
      logic        rdy;
      logic        chk_di;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          req_valid, req_ready, req_rw, req_signed;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_a;
   logic [31:0]   mem_di, mem_do;
   logic [1:0]    mem_size;
   logic          mem_rw, mem_e;

   logic          v2, rdy2, rw2, sg2, rv2, er2, mrw2, me2;
   logic [1:0]    sz2, msz2;
   logic [AW-1:0] a2, ma2;
   logic [31:0]   wd2, rd2, mdi2, mdo2;

   mem_access_unit #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do),
      .mem_size(mem_size), .mem_rw(mem_rw), .mem_e(mem_e)
   );

   mem_access_unit #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) dut_strict (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v2), .req_ready(rdy2), .req_rw(rw2),
      .req_size(sz2), .req_signed(sg2), .req_addr(a2),
      .req_wdata(wd2), .resp_valid(rv2), .resp_rdata(rd2),
      .resp_err(er2), .mem_a(ma2), .mem_di(mdi2), .mem_do(mdo2),
      .mem_size(msz2), .mem_rw(mrw2), .mem_e(me2)
   );

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];

   int   checks = 0, fails = 0;
   int   cyc = 0, acc_cnt = 0, last_acc_cyc = 0;
   int   last_resp_cyc = 0, resp_cnt = 0, e_cnt = 0, rw_cnt = 0, e2_cnt = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   logic [7:0]  a_log [4];
   logic        cur_ready = 1'b1;
   logic        chk_en = 1'b1, model_en = 1'b1;
   rec_t        q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r.a = '0; r.di = '0; r.sz = '0; r.rw = 1'b0; r.e = 1'b0;
      r.rv = 1'b0; r.err = 1'b0; r.rd = '0; r.rdy = 1'b1; r.chk_di = 1'b1;
      return r;
   endfunction

   // Big-endian read of n bytes from the reference memory, then extension
   function automatic logic [31:0] model_load(input logic [7:0] a, input int n, input logic sgn);
      longint v = 0;
      for (int k = 0; k < n; k++) v = v * 256 + longint'(ref_mem[8'(a + 8'(k))]);
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   // Memory: combinational big-endian reads, writes at the clock edge
   always_comb begin
      case (mem_size)
         2'b00:   mem_do = {24'h0, mem[mem_a]};
         2'b01:   mem_do = {16'h0, mem[mem_a], mem[8'(mem_a + 8'd1)]};
         default: mem_do = {mem[mem_a], mem[8'(mem_a + 8'd1)],
                            mem[8'(mem_a + 8'd2)], mem[8'(mem_a + 8'd3)]};
      endcase
   end

   always @(posedge clk) begin
      int n;
      if (mem_e) begin
         n = (mem_size == 2'b01) ? 2 : (mem_size == 2'b10) ? 4 : 1;
         for (int k = 0; k < n; k++)
            mem[8'(mem_a + 8'(k))] = 8'(mem_di >> (8 * (n - 1 - k)));
      end
   end

   // Reference model: expand each accepted request into expected cycles
   always @(posedge clk) begin
      int   n;
      bit   al;
      rec_t r;
      if (!rst_n) begin
         q.delete();
      end else if (model_en && req_valid && cur_ready) begin
         acc_cnt++;
         last_acc_cyc = cyc;
         n  = (req_size == 2'b01) ? 2 : (req_size == 2'b10) ? 4 : 1;
         al = (req_size == 2'b00) || (req_size == 2'b01 && req_addr % 2 == 0) ||
              (req_size == 2'b10 && req_addr % 4 == 0);
         if (req_size == 2'b11) begin
            r = idle_rec(); r.rdy = 1'b0; r.rv = 1'b1; r.err = 1'b1;
            q.push_back(r);
         end else begin
            if (al) begin
               r = idle_rec(); r.rdy = 1'b0;
               r.a = req_addr; r.di = req_wdata; r.sz = req_size;
               r.rw = req_rw; r.e = req_rw;
               q.push_back(r);
            end else begin
               for (int k = 0; k < n; k++) begin
                  r = idle_rec(); r.rdy = 1'b0;
                  r.a = 8'(req_addr + 8'(k)); r.rw = req_rw; r.e = req_rw;
                  r.chk_di = req_rw;
                  r.di = (req_wdata >> (8 * (n - 1 - k))) & 32'hFF;
                  q.push_back(r);
               end
            end
            r = idle_rec(); r.rdy = 1'b0; r.rv = 1'b1;
            r.rd = req_rw ? 32'h0 : model_load(req_addr, n, req_signed);
            q.push_back(r);
            if (req_rw)
               for (int k = 0; k < n; k++)
                  ref_mem[8'(req_addr + 8'(k))] = 8'(req_wdata >> (8 * (n - 1 - k)));
         end
      end
      cyc++;
   end

   // Compare process: every cycle against the model's expected trace
   always @(negedge clk) begin
      rec_t ex;
      int   d;
      if (!rst_n) begin
         q.delete();
         ex = idle_rec();
      end else if (q.size() != 0) ex = q.pop_front();
      else ex = idle_rec();
      cur_ready = ex.rdy;
      if (chk_en) begin
         chk("req_ready",  32'(req_ready),  32'(ex.rdy));
         chk("resp_valid", 32'(resp_valid), 32'(ex.rv));
         chk("resp_err",   32'(resp_err),   32'(ex.err));
         chk("resp_rdata", resp_rdata,      ex.rd);
         chk("mem_a",      32'(mem_a),      32'(ex.a));
         chk("mem_size",   32'(mem_size),   32'(ex.sz));
         chk("mem_rw",     32'(mem_rw),     32'(ex.rw));
         chk("mem_e",      32'(mem_e),      32'(ex.e));
         if (ex.chk_di) chk("mem_di", mem_di, ex.di);
      end
      if (resp_valid) begin
         resp_cnt++;
         last_resp_cyc = cyc;
         last_rdata = resp_rdata;
         last_err = resp_err;
      end
      if (mem_e)  e_cnt++;
      if (mem_rw) rw_cnt++;
      if (me2)    e2_cnt++;
      d = cyc - last_acc_cyc;
      if (d >= 1 && d <= 4) a_log[d-1] = mem_a;
   end

   task automatic wait_idle();
      for (int i = 0; i < 40 && q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      chk("idle_reached", 32'(q.size() == 0), 32'd1);
   endtask

   task automatic do_req(input logic rw, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd);
      int a0;
      @(negedge clk);
      e_cnt = 0; rw_cnt = 0;
      req_rw = rw; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
         @(posedge clk); #1;
      end
      chk("accept_seen", 32'(acc_cnt != a0), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
   endtask

   task automatic rand_fields();
      int r;
      r = $urandom_range(0, 7);
      req_size   = (r == 7) ? 2'b11 : 2'(r % 3);
      req_addr   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      req_rw     = 1'($urandom);
      req_signed = 1'($urandom);
      req_wdata  = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, acc1, acc2;
      logic [7:0] b20, b23;
      rst_n = 1'b1;
      req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      v2 = 1'b0; rw2 = 1'b0; sz2 = 2'b00; sg2 = 1'b0; a2 = '0; wd2 = '0;
      mdo2 = 32'h8765_4321;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata,      32'd0);
      chk("rst_resp_err",   32'(resp_err),   32'd0);
      chk("rst_mem_a",      32'(mem_a),      32'd0);
      chk("rst_mem_di",     mem_di,          32'd0);
      chk("rst_mem_size",   32'(mem_size),   32'd0);
      chk("rst_mem_rw",     32'(mem_rw),     32'd0);
      chk("rst_mem_e",      32'(mem_e),      32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Strict instance: misaligned rejected, aligned still served
      @(negedge clk);
      chk("strict_ready0", 32'(rdy2), 32'd1);
      v2 = 1'b1; rw2 = 1'b1; sz2 = SZ_WORD; a2 = 8'h03; wd2 = 32'hCAFE_F00D;
      @(negedge clk);
      v2 = 1'b0;
      chk("strict_err_valid", 32'(rv2),  32'd1);
      chk("strict_err",       32'(er2),  32'd1);
      chk("strict_err_rdata", rd2,       32'd0);
      chk("strict_err_ready", 32'(rdy2), 32'd0);
      @(negedge clk);
      chk("strict_rv_drop", 32'(rv2),  32'd0);
      chk("strict_ready1",  32'(rdy2), 32'd1);
      v2 = 1'b1; rw2 = 1'b0; sz2 = SZ_WORD; a2 = 8'h04;
      @(negedge clk);
      v2 = 1'b0;
      chk("strict_mem_a",    32'(ma2),  32'h04);
      chk("strict_mem_size", 32'(msz2), 32'(SZ_WORD));
      chk("strict_early_rv", 32'(rv2),  32'd0);
      @(negedge clk);
      chk("strict_load_valid", 32'(rv2), 32'd1);
      chk("strict_load_err",   32'(er2), 32'd0);
      chk("strict_load_rdata", rd2,      32'h8765_4321);
      chk("strict_no_mem_e",   32'(e2_cnt), 32'd0);

      // Aligned word store
      do_req(1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEAD_BEEF);
      chk("st_bytes",   {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEAD_BEEF);
      chk("st_e_cycles", 32'(e_cnt), 32'd1);
      chk("st_latency",  32'(last_resp_cyc - last_acc_cyc), 32'd2);
      chk("st_err",      32'(last_err), 32'd0);
      chk("st_rdata",    last_rdata, 32'd0);

      // Aligned loads
      do_req(1'b0, SZ_BYTE, 1'b1, 8'h11, 32'h0);
      chk("ld_sbyte", last_rdata, 32'hFFFF_FFAD);
      do_req(1'b0, SZ_HALF, 1'b0, 8'h12, 32'h0);
      chk("ld_uhalf", last_rdata, 32'h0000_BEEF);
      do_req(1'b0, SZ_HALF, 1'b1, 8'h12, 32'h0);
      chk("ld_shalf", last_rdata, 32'hFFFF_BEEF);
      chk("ld_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd2);

      // Misaligned word load wrapping past the top of memory
      mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
      ref_mem[8'hFE] = 8'h11; ref_mem[8'hFF] = 8'h22; ref_mem[8'h00] = 8'h33; ref_mem[8'h01] = 8'h44;
      do_req(1'b0, SZ_WORD, 1'b0, 8'hFE, 32'h0);
      chk("wrap_rdata",   last_rdata, 32'h1122_3344);
      chk("wrap_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd5);
      chk("wrap_addrs",   {a_log[0], a_log[1], a_log[2], a_log[3]}, 32'hFEFF_0001);

      // Misaligned half store
      b20 = mem[8'h20]; b23 = mem[8'h23];
      do_req(1'b1, SZ_HALF, 1'b0, 8'h21, 32'h0000_A55A);
      chk("hst_bytes",  {16'h0, mem[8'h21], mem[8'h22]}, 32'h0000_A55A);
      chk("hst_below",  32'(mem[8'h20]), 32'(b20));
      chk("hst_above",  32'(mem[8'h23]), 32'(b23));
      chk("hst_e_cycles", 32'(e_cnt), 32'd2);

      // Illegal size
      do_req(1'b1, 2'b11, 1'b0, 8'h30, 32'h1234_5678);
      chk("ill_err",     32'(last_err), 32'd1);
      chk("ill_latency", 32'(last_resp_cyc - last_acc_cyc), 32'd1);
      chk("ill_no_e",    32'(e_cnt),  32'd0);
      chk("ill_no_rw",   32'(rw_cnt), 32'd0);
      chk("ill_rdata",   last_rdata, 32'd0);

      // Back-to-back with req_valid held high
      @(negedge clk);
      req_rw = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 8'h10;
      req_valid = 1'b1;
      a0 = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) begin @(posedge clk); #1; end
      acc1 = last_acc_cyc;
      @(negedge clk);
      req_size = SZ_BYTE; req_signed = 1'b1; req_addr = 8'h13;
      a0 = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) begin @(posedge clk); #1; end
      acc2 = last_acc_cyc;
      chk("b2b_accepted", 32'(acc_cnt != a0), 32'd1);
      chk("b2b_gap", 32'(acc2 - acc1), 32'd3);
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      chk("b2b_rdata", last_rdata, 32'hFFFF_FFEF);

      // Randomized traffic, including requests presented while busy
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         req_valid = ($urandom_range(0, 2) != 0);
         rand_fields();
      end
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      for (int i = 0; i < 256; i++) chk($sformatf("mem[%0h]", i), 32'(mem[i]), 32'(ref_mem[i]));

      // Reset during byte 2 of a split word store to 0x41
      chk_en = 1'b0; model_en = 1'b0;
      for (int i = 8'h40; i <= 8'h45; i++) mem[i] = 8'h00;
      @(negedge clk);
      req_rw = 1'b1; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 8'h41;
      req_wdata = 32'h1122_3344; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      resp_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_e_before", 32'(mem_e), 32'd1);
      chk("rst_mid_a_before", 32'(mem_a), 32'h43);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_e",     32'(mem_e),      32'd0);
      chk("rst_mid_rw",    32'(mem_rw),     32'd0);
      chk("rst_mid_a",     32'(mem_a),      32'd0);
      chk("rst_mid_ready", 32'(req_ready),  32'd1);
      chk("rst_mid_rv",    32'(resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_no_resp", 32'(resp_cnt), 32'd0);
      chk("rst_mid_bytes", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h0011_2200);
      chk("rst_mid_b44",   32'(mem[8'h44]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
